// File: rtl/sram_burst_ctrl_pkg.sv
// Shared definitions for the MT45W8 pseudo-SRAM burst controller:
// FSM state encodings, pin polarity constants and small state decoders.
package sram_burst_ctrl_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_BURST = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;

  // Pin polarity constants (active-high and active-low strobes)
  localparam logic ASSERT     = 1'b1;
  localparam logic DEASSERT   = 1'b0;
  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;

  // Watchdog counter width
  localparam int WD_W = 8;

  typedef enum logic {DIR_RD = 1'b0, DIR_WR = 1'b1} dir_e;

  // Cycles where the device may present or accept a data beat
  function automatic logic in_data_phase(input logic [2:0] st);
    return (st == ST_WAIT) || (st == ST_BURST);
  endfunction

  // Cycles where the chip is selected (ADDR through last beat)
  function automatic logic in_txn(input logic [2:0] st);
    return (st == ST_ADDR) || in_data_phase(st);
  endfunction

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Host-side request/response bus of the pseudo-SRAM burst controller.
// master = system bus side, slave = controller side.
interface sram_burst_ctrl_if #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 16
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [A_WIDTH-1:0] req_addr;
  logic [D_WIDTH-1:0] wdata;
  logic               wdata_ack;
  logic [D_WIDTH-1:0] rdata;
  logic               rdata_valid;
  logic               done;
  logic               err;

  modport master (
    output req_valid, req_we, req_addr, wdata,
    input  req_ready, wdata_ack, rdata, rdata_valid, done, err
  );

  modport slave (
    input  req_valid, req_we, req_addr, wdata,
    output req_ready, wdata_ack, rdata, rdata_valid, done, err
  );
endinterface

// File: rtl/sram_burst_ctrl_count_reg.sv
// count_reg: loadable up-counter with enable, async active-low reset.
// Load has priority over count enable.
module count_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  // load wins, otherwise count up when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= load_val;
    else if (en)   q <= q + 1'b1;
  end

endmodule

// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: host-side controller for the MT45W8 pseudo-SRAM in
// fixed-latency burst mode. One read or write burst of BURST_LEN words per
// request: ADDR/ADV cycle, ride out mem_wait, move the words, pulse done.
// Optional watchdog on the wait phase: define SRAM_CTRL_TIMEOUT_EN.
module sram_burst_ctrl
  import sram_burst_ctrl_pkg::*;
#(
  parameter int D_WIDTH     = 16,
  parameter int A_WIDTH     = 16,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_L,
  sram_burst_ctrl_if.slave   bus,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic               mem_adv_L,
  output logic               mem_ce_L,
  output logic               mem_oe_L,
  output logic               mem_we_L,
  input  logic               mem_wait,
  inout  wire  [D_WIDTH-1:0] mem_data,
  output logic               mem_ub_L,
  output logic               mem_lb_L,
  output logic               mem_cre
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  // Reject configurations the counters cannot represent
  if (BURST_LEN < 1 || BURST_LEN > 16 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
    $error("sram_burst_ctrl: BURST_LEN must be 1..16 and TIMEOUT_CYC 1..255");
  end

  logic [2:0]         state, nxt;
  logic [A_WIDTH-1:0] lat_addr;
  dir_e               lat_dir;
  logic [CNT_W-1:0]   beat_cnt;
  logic               accept, beat, last, is_wr;
  logic               wd_hit;
  logic [D_WIDTH-1:0] rdata_q;
  logic               rdata_vld_q;

  assign accept = bus.req_valid && (state == ST_IDLE);
  assign is_wr  = (lat_dir == DIR_WR);
  // a beat moves one word; the first one lands in WAIT when mem_wait drops
  assign beat   = in_data_phase(state) && !mem_wait;
  assign last   = (beat_cnt == LAST_BEAT);

  // Beat counter: cleared in ADDR, advanced once per beat
  count_reg #(.W(CNT_W)) u_beat_cnt (
    .clk      (clk),
    .rst_n    (rst_L),
    .load     (state == ST_ADDR),
    .en       (beat),
    .load_val ('0),
    .q        (beat_cnt)
  );

`ifdef SRAM_CTRL_TIMEOUT_EN
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // The limit is compared against the registered count, so the abort is
  // taken on the cycle the count already equals TIMEOUT_CYC.
  assign wd_hit = (state == ST_WAIT) && mem_wait && (wd_cnt == WD_W'(TIMEOUT_CYC));

  // Watchdog: counts stalled WAIT cycles, restarts with every burst
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L)                                    wd_cnt <= '0;
    else if (state == ST_ADDR)                     wd_cnt <= '0;
    else if (state == ST_WAIT && mem_wait && !wd_hit) wd_cnt <= wd_cnt + 1'b1;
  end

  // err lines up with the END cycle that follows the abort
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) err_q <= DEASSERT;
    else        err_q <= wd_hit;
  end

  assign bus.err = err_q;
`else
  assign wd_hit  = 1'b0;
  assign bus.err = DEASSERT;
`endif

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (accept) nxt = ST_ADDR;
      ST_ADDR:  nxt = ST_WAIT;
      ST_WAIT: begin
        if (!mem_wait)   nxt = last ? ST_END : ST_BURST;
        else if (wd_hit) nxt = ST_END;
      end
      ST_BURST: if (!mem_wait && last) nxt = ST_END;
      ST_END:   nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any burst without a done pulse
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Latch the request on accept; held steady for the whole burst
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      lat_addr <= '0;
      lat_dir  <= DIR_RD;
    end else if (accept) begin
      lat_addr <= bus.req_addr;
      lat_dir  <= bus.req_we ? DIR_WR : DIR_RD;
    end
  end

  // Read capture: word sampled at the beat edge, valid the following cycle
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      rdata_q     <= '0;
      rdata_vld_q <= DEASSERT;
    end else begin
      rdata_vld_q <= beat && !is_wr;
      if (beat && !is_wr) rdata_q <= mem_data;
    end
  end

  assign bus.req_ready   = (state == ST_IDLE) ? ASSERT : DEASSERT;
  assign bus.wdata_ack   = (beat && is_wr) ? ASSERT : DEASSERT;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_vld_q;
  assign bus.done        = (state == ST_END) ? ASSERT : DEASSERT;

  assign mem_addr  = lat_addr;
  assign mem_adv_L = (state == ST_ADDR) ? ASSERT_L : DEASSERT_L;
  assign mem_ce_L  = in_txn(state) ? ASSERT_L : DEASSERT_L;
  assign mem_oe_L  = (in_data_phase(state) && !is_wr) ? ASSERT_L : DEASSERT_L;
  assign mem_we_L  = (in_txn(state) && is_wr) ? ASSERT_L : DEASSERT_L;
  assign mem_ub_L  = ASSERT_L;
  assign mem_lb_L  = ASSERT_L;
  assign mem_cre   = DEASSERT;

  // Only drive the data pins while a write owns them
  assign mem_data = (in_data_phase(state) && is_wr) ? bus.wdata : 'z;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: two DUTs (BURST_LEN 4 and 1) sharing one
// fixed-latency (LATENCY 4) pseudo-SRAM model through a select mux.
// Read data is checked by a scoreboard queue; timing via per-cycle masks.
module tb_sram_burst_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_L;
  int   errors = 0;
  int   checks = 0;

  sram_burst_ctrl_if #(.D_WIDTH(16), .A_WIDTH(16)) bus0 ();
  sram_burst_ctrl_if #(.D_WIDTH(16), .A_WIDTH(16)) bus1 ();

  logic [15:0] mem_addr0, mem_addr1;
  logic        adv0, ce0, oe0, we0, ub0, lb0, cre0;
  logic        adv1, ce1, oe1, we1, ub1, lb1, cre1;
  wire  [15:0] md0, md1;
  logic        m_wait;

  sram_burst_ctrl #(.D_WIDTH(16), .A_WIDTH(16), .BURST_LEN(4), .TIMEOUT_CYC(8)) dut0 (
    .clk(clk), .rst_L(rst_L), .bus(bus0),
    .mem_addr(mem_addr0), .mem_adv_L(adv0), .mem_ce_L(ce0), .mem_oe_L(oe0),
    .mem_we_L(we0), .mem_wait(m_wait), .mem_data(md0),
    .mem_ub_L(ub0), .mem_lb_L(lb0), .mem_cre(cre0)
  );

  sram_burst_ctrl #(.D_WIDTH(16), .A_WIDTH(16), .BURST_LEN(1), .TIMEOUT_CYC(8)) dut1 (
    .clk(clk), .rst_L(rst_L), .bus(bus1),
    .mem_addr(mem_addr1), .mem_adv_L(adv1), .mem_ce_L(ce1), .mem_oe_L(oe1),
    .mem_we_L(we1), .mem_wait(m_wait), .mem_data(md1),
    .mem_ub_L(ub1), .mem_lb_L(lb1), .mem_cre(cre1)
  );

  // ---------------- pseudo-SRAM model (LATENCY 4) ----------------
  logic        sel;         // 0: dut0 owns the device, 1: dut1
  logic        force_wait;  // stub: hold mem_wait high
  logic [15:0] mem [0:65535];
  logic        act, mwe;
  logic [2:0]  lat;
  logic [15:0] maddr;

  wire [15:0] p_addr = sel ? mem_addr1 : mem_addr0;
  wire        p_adv  = sel ? adv1 : adv0;
  wire        p_ce   = sel ? ce1 : ce0;
  wire        p_oe   = sel ? oe1 : oe0;
  wire        p_we   = sel ? we1 : we0;
  wire [15:0] p_din  = sel ? md1 : md0;

  assign m_wait = force_wait | (act && lat != 3'd4);
  wire m_beat = act && !p_ce && !m_wait;
  wire m_drv  = m_beat && !mwe && !p_oe;
  assign md0 = (m_drv && !sel) ? mem[maddr] : 'z;
  assign md1 = (m_drv &&  sel) ? mem[maddr] : 'z;

  // device: latch on ADV, wait 3 cycles, then one word per beat
  always @(posedge clk) begin
    if (p_ce) act <= 1'b0;
    else if (!p_adv) begin
      act   <= 1'b1;
      lat   <= 3'd1;
      maddr <= p_addr;
      mwe   <= !p_we;
    end else if (act) begin
      if (lat != 3'd4) lat <= lat + 3'd1;
      if (m_beat) begin
        if (mwe) mem[maddr] <= p_din;
        maddr <= maddr + 16'd1;
      end
    end
  end

  // ---------------- read-data scoreboard ----------------
  logic [15:0] exp_q [$];
  logic        sb_off;

  always @(negedge clk) begin
    if (!sb_off && (bus0.rdata_valid || bus1.rdata_valid)) begin
      logic [15:0] got, want;
      got = bus0.rdata_valid ? bus0.rdata : bus1.rdata;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got %h want none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL sb_rdata: got %h want %h", got, want);
        end
      end
    end
  end

  // ---------------- helpers (stimulus and sampling only) ----------------
  logic [15:0] wr_words [0:3];
  logic [31:0] m_ack, m_rv, m_done, m_err, m_adv, m_oe, m_we, m_rdy;
  int          drop_at;

  // Present a request to the selected DUT; return at posedge+1 of ADDR (t0)
  task start_req(input logic we, input logic [15:0] addr, input logic hold);
    int k;
    if (sel) begin
      bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_addr = addr;
    end else begin
      bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_addr = addr;
      bus0.wdata = wr_words[0];
    end
    k = 0;
    @(negedge clk);
    while (!(sel ? bus1.req_ready : bus0.req_ready) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      errors++; checks++;
      $display("FAIL req_ready_timeout: got 0 want 1 within 100 cycles");
    end
    @(posedge clk); #1;
    if (!hold) begin
      bus0.req_valid = 1'b0;
      bus1.req_valid = 1'b0;
    end
  endtask

  // Record n cycles of outputs as bit masks (bit i = cycle ti), feeding wdata
  task capture(input int n);
    int idx;
    idx = 0;
    m_ack = 0; m_rv = 0; m_done = 0; m_err = 0; m_adv = 0; m_oe = 0; m_we = 0; m_rdy = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_ack[i]  = sel ? bus1.wdata_ack   : bus0.wdata_ack;
      m_rv[i]   = sel ? bus1.rdata_valid : bus0.rdata_valid;
      m_done[i] = sel ? bus1.done        : bus0.done;
      m_err[i]  = sel ? bus1.err         : bus0.err;
      m_rdy[i]  = sel ? bus1.req_ready   : bus0.req_ready;
      m_adv[i]  = !p_adv;
      m_oe[i]   = !p_oe;
      m_we[i]   = !p_we;
      @(posedge clk); #1;
      if (m_ack[i] && idx < 3) begin
        idx++;
        bus0.wdata = wr_words[idx];
      end
      if (i + 1 == drop_at) bus0.req_valid = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task test_reset;
    rst_L = 1'b0;
    #1;
    checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus0.req_ready); end
    checks++; if ({bus0.wdata_ack, bus0.rdata_valid, bus0.done, bus0.err} !== 4'b0) begin errors++; $display("FAIL rst_strobes: got %b want 0000", {bus0.wdata_ack, bus0.rdata_valid, bus0.done, bus0.err}); end
    checks++; if (bus0.rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0000", bus0.rdata); end
    checks++; if ({adv0, ce0, oe0, we0} !== 4'hF) begin errors++; $display("FAIL rst_pins_L: got %b want 1111", {adv0, ce0, oe0, we0}); end
    checks++; if ({adv1, ce1, oe1, we1} !== 4'hF) begin errors++; $display("FAIL rst_pins1_L: got %b want 1111", {adv1, ce1, oe1, we1}); end
    checks++; if ({ub0, lb0, cre0, ub1, lb1, cre1} !== 6'b0) begin errors++; $display("FAIL tie_offs: got %b want 000000", {ub0, lb0, cre0, ub1, lb1, cre1}); end
    repeat (2) @(posedge clk);
    #3 rst_L = 1'b1;
    @(posedge clk); #1;
  endtask

  task test_write;
    wr_words[0] = 16'h00A1; wr_words[1] = 16'h00A2; wr_words[2] = 16'h00A3; wr_words[3] = 16'h00A4;
    start_req(1'b1, 16'h0010, 1'b0);
    capture(12);
    checks++; if (m_adv !== 32'h001) begin errors++; $display("FAIL wr_adv: got %h want 001", m_adv); end
    checks++; if (m_ack !== 32'h0F0) begin errors++; $display("FAIL wr_ack: got %h want 0f0", m_ack); end
    checks++; if (m_done !== 32'h100) begin errors++; $display("FAIL wr_done: got %h want 100", m_done); end
    checks++; if (m_we !== 32'h0FF) begin errors++; $display("FAIL wr_we_L: got %h want 0ff", m_we); end
    checks++; if (m_oe !== 32'h0) begin errors++; $display("FAIL wr_oe_L: got %h want 0", m_oe); end
    checks++; if (m_rdy !== 32'hE00) begin errors++; $display("FAIL wr_ready: got %h want e00", m_rdy); end
    checks++; if (m_err !== 32'h0) begin errors++; $display("FAIL wr_err: got %h want 0", m_err); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h0010 + 16'(i)] !== wr_words[i]) begin
        errors++; $display("FAIL wr_mem[%0d]: got %h want %h", i, mem[16'h0010 + 16'(i)], wr_words[i]);
      end
    end
  endtask

  task test_read;
    exp_q.push_back(16'h00A1); exp_q.push_back(16'h00A2);
    exp_q.push_back(16'h00A3); exp_q.push_back(16'h00A4);
    start_req(1'b0, 16'h0010, 1'b0);
    capture(12);
    checks++; if (m_rv !== 32'h1E0) begin errors++; $display("FAIL rd_valid: got %h want 1e0", m_rv); end
    checks++; if (m_done !== 32'h100) begin errors++; $display("FAIL rd_done: got %h want 100", m_done); end
    checks++; if (m_oe !== 32'h0FE) begin errors++; $display("FAIL rd_oe_L: got %h want 0fe", m_oe); end
    checks++; if (m_we !== 32'h0) begin errors++; $display("FAIL rd_we_L: got %h want 0", m_we); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rd_sb_left: got %0d want 0", exp_q.size()); end
  endtask

  task test_back_to_back;
    wr_words[0] = 16'h00B1; wr_words[1] = 16'h00B2; wr_words[2] = 16'h00B3; wr_words[3] = 16'h00B4;
    exp_q.push_back(16'h00B1); exp_q.push_back(16'h00B2);
    exp_q.push_back(16'h00B3); exp_q.push_back(16'h00B4);
    drop_at = 10;
    start_req(1'b1, 16'h0020, 1'b1);
    bus0.req_we = 1'b0;  // next request, presented while the write runs
    capture(22);
    drop_at = -1;
    checks++; if (m_adv !== 32'h401) begin errors++; $display("FAIL b2b_adv: got %h want 401", m_adv); end
    checks++; if (m_ack !== 32'h0F0) begin errors++; $display("FAIL b2b_ack: got %h want 0f0", m_ack); end
    checks++; if (m_rv !== 32'h78000) begin errors++; $display("FAIL b2b_rv: got %h want 78000", m_rv); end
    checks++; if (m_done !== 32'h40100) begin errors++; $display("FAIL b2b_done: got %h want 40100", m_done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_sb_left: got %0d want 0", exp_q.size()); end
  endtask

  task test_reset_mid_read;
    int dn;
    sb_off = 1'b1;
    start_req(1'b0, 16'h0010, 1'b0);
    capture(5);           // t0..t4, now inside t5
    rst_L = 1'b0;
    #1;
    checks++; if ({adv0, ce0, oe0, we0} !== 4'hF) begin errors++; $display("FAIL mid_rst_pins_L: got %b want 1111", {adv0, ce0, oe0, we0}); end
    checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", bus0.req_ready); end
    checks++; if ({bus0.rdata_valid, bus0.rdata} !== 17'h0) begin errors++; $display("FAIL mid_rst_rdata: got %h want 0", {bus0.rdata_valid, bus0.rdata}); end
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus0.done) dn++;
    end
    #2 rst_L = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus0.done) dn++;
    end
    checks++; if (dn != 0 || m_done != 32'h0) begin errors++; $display("FAIL mid_rst_done: got %0d want 0", dn); end
    sb_off = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(16'h00A1); exp_q.push_back(16'h00A2);
    exp_q.push_back(16'h00A3); exp_q.push_back(16'h00A4);
    start_req(1'b0, 16'h0010, 1'b0);
    capture(12);
    checks++; if (m_rv !== 32'h1E0) begin errors++; $display("FAIL post_rst_rv: got %h want 1e0", m_rv); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL post_rst_sb_left: got %0d want 0", exp_q.size()); end
  endtask

`ifdef SRAM_CTRL_TIMEOUT_EN
  task test_timeout;
    force_wait = 1'b1;
    start_req(1'b0, 16'h0030, 1'b0);
    capture(14);
    force_wait = 1'b0;
    checks++; if (m_done !== 32'h400) begin errors++; $display("FAIL to_done: got %h want 400", m_done); end
    checks++; if (m_err !== 32'h400) begin errors++; $display("FAIL to_err: got %h want 400", m_err); end
    checks++; if ((m_rv | m_ack) !== 32'h0) begin errors++; $display("FAIL to_beats: got %h want 0", m_rv | m_ack); end
    checks++; if (m_rdy !== 32'h3800) begin errors++; $display("FAIL to_ready: got %h want 3800", m_rdy); end
  endtask
`else
  task test_no_timeout;
    exp_q.push_back(16'h00A1); exp_q.push_back(16'h00A2);
    exp_q.push_back(16'h00A3); exp_q.push_back(16'h00A4);
    force_wait = 1'b1;
    start_req(1'b0, 16'h0010, 1'b0);
    capture(20);
    checks++; if ((m_done | m_err | m_rv) !== 32'h0) begin errors++; $display("FAIL nto_stall: got %h want 0", m_done | m_err | m_rv); end
    force_wait = 1'b0;
    capture(8);
    checks++; if (m_rv !== 32'h1E) begin errors++; $display("FAIL nto_rv: got %h want 1e", m_rv); end
    checks++; if (m_done !== 32'h10) begin errors++; $display("FAIL nto_done: got %h want 10", m_done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL nto_sb_left: got %0d want 0", exp_q.size()); end
  endtask
`endif

  task test_burst1;
    sel = 1'b1;
    exp_q.push_back(16'h00A4);
    start_req(1'b0, 16'h0013, 1'b0);
    capture(8);
    sel = 1'b0;
    checks++; if (m_adv !== 32'h01) begin errors++; $display("FAIL b1_adv: got %h want 01", m_adv); end
    checks++; if (m_rv !== 32'h20) begin errors++; $display("FAIL b1_rv: got %h want 20", m_rv); end
    checks++; if (m_done !== 32'h20) begin errors++; $display("FAIL b1_done: got %h want 20", m_done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b1_sb_left: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    sel = 1'b0; force_wait = 1'b0; sb_off = 1'b0; drop_at = -1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_read();
`ifdef SRAM_CTRL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_burst1();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
